// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  localparam int UART_BAUD_DIV   = 5207;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  logic [IDX_W-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Define UART_TX_ARBITER_LOCK_EN to hold a grant across bytes until LAST is acked.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [8*N_REQ-1:0]   DATA_IN,
  input  logic [N_REQ-1:0]     LAST,
  output logic [N_REQ-1:0]     ACK,
  output logic [N_REQ-1:0]     GRANT,
  output logic                 TX_START,
  output logic [7:0]           TX_DATA,
  input  logic                 TX_BUSY,
  output logic                 ERR
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic [7:0]       win_byte;

`ifdef UART_TX_ARBITER_LOCK_EN
  logic locked_q, locked_d;
  logic win_last;

  // While a packet is open only the current owner may be picked.
  assign elig     = locked_q ? (REQ & grant_q) : REQ;
  assign win_last = |(LAST & win_oh);
`else
  logic unused_last;

  assign unused_last = ^LAST;
  assign elig        = REQ;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .gnt (win_oh),
    .idx (win_idx),
    .vld (win_vld)
  );

  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) win_byte = DATA_IN[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
`ifdef UART_TX_ARBITER_LOCK_EN
    locked_d   = locked_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld && !TX_BUSY) begin
          state_d    = ISSUE;
          grant_d    = win_oh;
          ack_d      = win_oh;
          tx_start_d = 1'b1;
          tx_data_d  = win_byte;
          ptr_d      = win_idx;
`ifdef UART_TX_ARBITER_LOCK_EN
          locked_d   = !win_last;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never accepted: drop the byte and release everything.
          state_d = IDLE;
          err_d   = 1'b1;
          grant_d = '0;
`ifdef UART_TX_ARBITER_LOCK_EN
          locked_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          state_d = IDLE;
`ifdef UART_TX_ARBITER_LOCK_EN
          if (!locked_q) grant_d = '0;
`else
          grant_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(N_REQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef UART_TX_ARBITER_LOCK_EN
      locked_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef UART_TX_ARBITER_LOCK_EN
      locked_q   <= locked_d;
`endif
    end
  end

  assign ACK      = ack_q;
  assign GRANT    = grant_q;
  assign TX_START = tx_start_q;
  assign TX_DATA  = tx_data_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester FIFOs, a simple transmitter model and a rule-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ, LAST, ACK, GRANT;
  logic [8*N-1:0] DATA_IN;
  logic           TX_START;
  logic [7:0]     TX_DATA;
  logic           TX_BUSY;
  logic           ERR;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA_IN(DATA_IN), .LAST(LAST),
    .ACK(ACK), .GRANT(GRANT), .TX_START(TX_START), .TX_DATA(TX_DATA),
    .TX_BUSY(TX_BUSY), .ERR(ERR)
  );

  // Transmitter: accepts on the edge that samples START, busy for frame_len cycles.
  int busy_cnt   = 0;
  int preload    = 0;
  int frame_len  = 4;
  bit never_busy = 1'b0;

  always @(posedge CLK) begin
    if (preload > 0)                   busy_cnt <= preload;
    else if (TX_START && !never_busy)  busy_cnt <= frame_len;
    else if (busy_cnt > 0)             busy_cnt <= busy_cnt - 1;
  end
  assign TX_BUSY = (busy_cnt != 0);

  // Requester byte FIFOs: entry = {last, byte}.
  logic [8:0] fifo [N][64];
  int wr_i [N];
  int rd_i [N];
  int n_push = 0, n_pop = 0;

  // Reference model state.
  int         ptr_m  = N - 1;
  int         lock_m = -1;
  logic [N-1:0] req_prev = '0;
  bit         busy_prev = 1'b0;
  int         seen_id[$];
  logic [7:0] seen_byte[$];

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    fifo[i][wr_i[i] % 64] = {l, b};
    wr_i[i]++;
    n_push++;
  endtask

  function automatic bit fifos_empty();
    for (int i = 0; i < N; i++) if (wr_i[i] != rd_i[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int fifo_len(input int i);
    return wr_i[i] - rd_i[i];
  endfunction

  // Winner by the round-robin rule: first pending requester after the last winner.
  function automatic int model_pick(input logic [N-1:0] r);
    int j;
    if (lock_m >= 0) return r[lock_m] ? lock_m : -1;
    for (int k = 1; k <= N; k++) begin
      j = (ptr_m + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (wr_i[i] != rd_i[i]) begin
        e = fifo[i][rd_i[i] % 64];
        REQ[i] = 1'b1;
        DATA_IN[8*i +: 8] = e[7:0];
        LAST[i] = e[8];
      end else begin
        REQ[i] = 1'b0;
        DATA_IN[8*i +: 8] = 8'h00;
        LAST[i] = 1'b0;
      end
    end
    req_prev  = REQ;
    busy_prev = TX_BUSY;
  endtask

  task automatic step();
    int w;
    logic [8:0] e;
    @(negedge CLK);
    if (TX_START) begin
      w = model_pick(req_prev);
      chk("start_has_winner", 32'(w >= 0), 1);
      chk("start_not_busy", 32'(busy_prev), 0);
      if (w >= 0) begin
        e = fifo[w][rd_i[w] % 64];
        chk("grant", 32'(GRANT), 32'(1 << w));
        chk("ack", 32'(ACK), 32'(1 << w));
        chk("tx_data", 32'(TX_DATA), 32'(e[7:0]));
        rd_i[w]++;
        n_pop++;
        ptr_m = w;
        seen_id.push_back(w);
        seen_byte.push_back(TX_DATA);
`ifdef UART_TX_ARBITER_LOCK_EN
        lock_m = (e[8] || never_busy) ? -1 : w;
`endif
      end
    end else begin
      chk("ack_quiet", 32'(ACK), 0);
    end
    drive();
  endtask

  task automatic wait_start(input string tag, input int cap);
    bit got = 1'b0;
    for (int n = 0; n < cap && !got; n++) begin
      step();
      got = TX_START;
    end
    chk(tag, 32'(got), 1);
  endtask

  // Waits for BUSY to rise then fall; checks GRANT held then cleared.
  task automatic wait_fall(input string tag, input logic [N-1:0] owner);
    bit hi = 1'b0, fell = 1'b0;
    for (int n = 0; n < 60 && !fell; n++) begin
      step();
      if (TX_BUSY) hi = 1'b1;
      else if (hi) fell = 1'b1;
    end
    chk({tag, "_fell"}, 32'(fell), 1);
    chk({tag, "_grant_hold"}, 32'(GRANT), 32'(owner));
    step();
    chk({tag, "_grant_clr"}, 32'(GRANT), 0);
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
`ifdef UART_TX_ARBITER_LOCK_EN
      if (lock_m >= 0 && fifo_len(lock_m) == 0) begin
        push(lock_m, 8'hEE, 1'b1);
        drive();
      end
`endif
      step();
      done = fifos_empty() && !TX_BUSY;
    end
    step();
    step();
    chk(tag, 32'(done), 1);
  endtask

  task automatic quiet_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    ptr_m  = N - 1;
    lock_m = -1;
    drive();
  endtask

  initial begin
    logic [7:0] exp3 [5];
    int exp6 [4];
    RST = 1'b1;
    REQ = '0;
    DATA_IN = '0;
    LAST = '0;
    repeat (3) @(negedge CLK);
    chk("rst_grant", 32'(GRANT), 0);
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_start", 32'(TX_START), 0);
    chk("rst_data", 32'(TX_DATA), 0);
    chk("rst_err", 32'(ERR), 0);
    RST = 1'b0;
    drive();

    // Single request, one-cycle latency.
    push(0, 8'h41, 1'b1);
    drive();
    step();
    chk("t1_start", 32'(TX_START), 1);
    chk("t1_grant", 32'(GRANT), 32'h1);
    chk("t1_data", 32'(TX_DATA), 32'h41);
    wait_fall("t1", 4'b0001);

    // Request while a prior frame still holds BUSY.
    preload = 6;
    step();
    preload = 0;
    push(2, 8'h5A, 1'b1);
    drive();
    for (int n = 0; n < 20 && TX_BUSY; n++) begin
      step();
      chk("t2_hold", 32'(TX_START), 0);
    end
    step();
    chk("t2_start", 32'(TX_START), 1);
    chk("t2_data", 32'(TX_DATA), 32'h5A);
    wait_fall("t2", 4'b0100);

    // Saturated fairness from reset.
    quiet_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
      push(i, 8'hA0 + 8'(i), 1'b1);
    end
    drive();
    seen_byte.delete();
    for (int k = 0; k < 5; k++) wait_start("t3_start", 30);
    exp3 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    chk("t3_count", 32'(seen_byte.size() >= 5), 1);
    for (int k = 0; k < 5 && k < seen_byte.size(); k++) chk("t3_seq", 32'(seen_byte[k]), 32'(exp3[k]));
    drain("t3_drain");

    // BUSY never rises: timeout after TMO cycles, then recovery.
    never_busy = 1'b1;
    push(3, 8'h77, 1'b1);
    drive();
    wait_start("t4_start", 20);
    for (int k = 0; k < TMO; k++) begin
      step();
      chk("t4_err_low", 32'(ERR), 0);
    end
    chk("t4_grant_wait", 32'(GRANT), 32'h8);
    step();
    chk("t4_err_set", 32'(ERR), 1);
    chk("t4_grant_clr", 32'(GRANT), 0);
    never_busy = 1'b0;
    push(1, 8'h78, 1'b1);
    drive();
    wait_start("t4_next", 10);
    chk("t4_err_sticky", 32'(ERR), 1);
    wait_fall("t4", 4'b0010);

    // Reset during WAIT_DONE; frame finishes in the transmitter.
    frame_len = 12;
    push(0, 8'h55, 1'b1);
    push(0, 8'h56, 1'b1);
    drive();
    wait_start("t5_start", 10);
    step();
    step();
    RST = 1'b1;
    #1;
    chk("t5_rst_grant", 32'(GRANT), 0);
    chk("t5_rst_ack", 32'(ACK), 0);
    chk("t5_rst_start", 32'(TX_START), 0);
    chk("t5_rst_data", 32'(TX_DATA), 0);
    chk("t5_rst_err", 32'(ERR), 0);
    @(negedge CLK);
    RST = 1'b0;
    ptr_m  = N - 1;
    lock_m = -1;
    drive();
    chk("t5_busy_left", 32'(TX_BUSY), 1);
    for (int n = 0; n < 30 && TX_BUSY; n++) begin
      step();
      chk("t5_hold", 32'(TX_START), 0);
    end
    step();
    chk("t5_restart", 32'(TX_START), 1);
    chk("t5_data", 32'(TX_DATA), 32'h56);
    frame_len = 4;
    wait_fall("t5", 4'b0001);

    // Packet lock behaviour.
    quiet_reset();
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b0);
    push(1, 8'h13, 1'b1);
    push(2, 8'h21, 1'b1);
    push(2, 8'h22, 1'b1);
    drive();
    seen_id.delete();
    for (int k = 0; k < 4; k++) wait_start("t6_start", 30);
`ifdef UART_TX_ARBITER_LOCK_EN
    exp6 = '{1, 1, 1, 2};
`else
    exp6 = '{1, 2, 1, 2};
`endif
    chk("t6_count", 32'(seen_id.size() >= 4), 1);
    for (int k = 0; k < 4 && k < seen_id.size(); k++) chk("t6_order", 32'(seen_id[k]), 32'(exp6[k]));
    drain("t6_drain");

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (fifo_len(i) < 3 && $urandom_range(0, 7) == 0)
          push(i, 8'($urandom), ($urandom_range(0, 3) == 0));
      end
      frame_len = $urandom_range(1, 5);
      drive();
      step();
    end
    drain("t7_drain");
    chk("t7_all_served", 32'(n_pop), 32'(n_push));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
